// File: rtl/edac_nlane_seq.sv
// Lane-sequential CRC-8 EDAC: one shared CRC datapath walks the lanes one per clock,
// encoding 4-bit nibbles into 12-bit codewords or checking codewords on read.
module edac_nlane_seq #(
  parameter int         LANES = 2,
  parameter logic [7:0] POLY  = 8'h97,
  parameter int         CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  start,
  input  logic                  READ,
  input  logic [LANES*12-1:0]   DIN,
  input  logic                  err_clr,
  output logic [LANES*12-1:0]   DOUT,
  output logic                  valid,
  output logic                  done,
  output logic                  busy,
  output logic [LANES-1:0]      err_mask,
  output logic [CNT_W-1:0]      err_count
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int POP_W = $clog2(LANES + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [LANES*12-1:0]   r_din;
  logic                  r_read;
  logic [LANES*12-1:0]   r_res, w_res;
  logic [LANES-1:0]      r_fail, w_fail;
  logic [LANES*12-1:0]   r_dout;
  logic                  r_valid;
  logic [LANES-1:0]      r_mask;
  logic [CNT_W-1:0]      r_cnt;
  logic [11:0]           w_lane;
  logic [3:0]            w_nib;
  logic [7:0]            w_crc;
  logic                  w_mis;
  logic                  w_last;

  function automatic logic [7:0] crc4(input logic [3:0] d);
    logic [7:0] c;
    c = '0;
    for (int b = 3; b >= 0; b--) begin
      if (c[7] ^ d[b]) c = {c[6:0], 1'b0} ^ POLY;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [POP_W-1:0] popcnt(input logic [LANES-1:0] f);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + POP_W'(f[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [POP_W-1:0] b);
    logic [SUM_W-1:0] s;
    logic [CNT_W-1:0] r;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) r = '1;
    else                           r = s[CNT_W-1:0];
    return r;
  endfunction

  // Lane datapath: write takes nibble idx, read takes codeword idx.
  assign w_lane = r_din[12*int'(r_idx) +: 12];
  assign w_nib  = r_read ? w_lane[11:8] : r_din[4*int'(r_idx) +: 4];
  assign w_crc  = crc4(w_nib);
  assign w_mis  = r_read && (w_crc != w_lane[7:0]);
  assign w_last = (r_idx == IDX_W'(LANES - 1));

  // Read results pack nibbles densely; the zero-cleared slots give the zero extension.
  always_comb begin
    w_res  = r_res;
    w_fail = r_fail;
    if (r_read) begin
      w_res[4*int'(r_idx) +: 4] = w_nib;
      w_fail[int'(r_idx)]       = w_mis;
    end else begin
      w_res[12*int'(r_idx) +: 12] = {w_nib, w_crc};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_mask  <= '0;
      r_cnt   <= '0;
    end else if (en) begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) r_idx <= '0;
      else if (r_state == S_RUN && !w_last) r_idx <= r_idx + IDX_W'(1);
      if (r_state == S_RUN && w_last) begin
        r_dout  <= (|w_fail) ? '1 : w_res;
        r_valid <= ~|w_fail;
        r_mask  <= w_fail;
      end
      if (err_clr) r_cnt <= '0;
      else if (r_state == S_RUN && w_last) r_cnt <= sat_add(r_cnt, popcnt(w_fail));
    end
  end

  // Operand capture and per-lane accumulation; no reset needed, cleared on every start.
  always_ff @(posedge CLK) begin
    if (en) begin
      if (r_state == S_IDLE && start) begin
        r_din  <= DIN;
        r_read <= READ;
        r_res  <= '0;
        r_fail <= '0;
      end else if (r_state == S_RUN) begin
        r_res  <= w_res;
        r_fail <= w_fail;
      end
    end
  end

  assign DOUT      = r_dout;
  assign valid     = r_valid;
  assign err_mask  = r_mask;
  assign err_count = r_cnt;
  assign done      = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_edac_nlane_seq.sv
// Bench for edac_nlane_seq: two instances (16-bit and 2-bit error counters) share
// stimulus; results are compared with a polynomial-division reference model.
module tb_edac_nlane_seq;

  localparam int         LANES = 2;
  localparam logic [7:0] POLY  = 8'h97;

  logic        CLK = 1'b0;
  logic        reset, en, start, READ, err_clr;
  logic [23:0] DIN;

  logic [23:0] dout_a, dout_b;
  logic        valid_a, valid_b, done_a, done_b, busy_a, busy_b;
  logic [1:0]  mask_a, mask_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;
  int exp_cnt_a = 0;
  int exp_cnt_b = 0;

  edac_nlane_seq #(.LANES(LANES), .POLY(POLY), .CNT_W(16)) u_dut_a (
    .CLK(CLK), .reset(reset), .en(en), .start(start), .READ(READ), .DIN(DIN),
    .err_clr(err_clr), .DOUT(dout_a), .valid(valid_a), .done(done_a),
    .busy(busy_a), .err_mask(mask_a), .err_count(cnt_a)
  );

  edac_nlane_seq #(.LANES(LANES), .POLY(POLY), .CNT_W(2)) u_dut_b (
    .CLK(CLK), .reset(reset), .en(en), .start(start), .READ(READ), .DIN(DIN),
    .err_clr(err_clr), .DOUT(dout_b), .valid(valid_b), .done(done_b),
    .busy(busy_b), .err_mask(mask_b), .err_count(cnt_b)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Codeword by long division of d*x^8 by the full generator x^8+POLY.
  function automatic logic [11:0] ref_cw(input logic [3:0] d);
    int rem;
    rem = int'(d) << 8;
    for (int b = 11; b >= 8; b--)
      if ((rem & (1 << b)) != 0) rem = rem ^ ((32'h100 | int'(POLY)) << (b - 8));
    return {d, rem[7:0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_op(input string tag, input logic rd, input logic [23:0] din,
                        input int freeze, input bit dbl_start, input bit clr_last,
                        input int hold);
    logic [23:0] exp_dout;
    logic [11:0] cw;
    logic [1:0]  exp_mask;
    int          nfail;
    int          lat;
    exp_dout = '0;
    exp_mask = '0;
    nfail    = 0;
    for (int i = 0; i < LANES; i++) begin
      if (rd) begin
        cw = din[12*i +: 12];
        if (ref_cw(cw[11:8]) != cw) begin
          exp_mask[i] = 1'b1;
          nfail++;
        end
        exp_dout[4*i +: 4] = cw[11:8];
      end else begin
        exp_dout[12*i +: 12] = ref_cw(din[4*i +: 4]);
      end
    end
    if (nfail > 0) exp_dout = '1;
    if (clr_last) begin
      exp_cnt_a = 0;
      exp_cnt_b = 0;
    end else begin
      exp_cnt_a = (exp_cnt_a + nfail > 65535) ? 65535 : exp_cnt_a + nfail;
      exp_cnt_b = (exp_cnt_b + nfail > 3) ? 3 : exp_cnt_b + nfail;
    end

    start = 1'b1;
    READ  = rd;
    DIN   = din;
    tick();
    start = dbl_start;
    READ  = ~rd;
    DIN   = 24'($urandom);
    chk({tag, "_busy_rise"}, busy_a, 1'b1);
    lat = 0;
    if (freeze > 0) begin
      en = 1'b0;
      repeat (freeze) begin
        tick();
        lat++;
      end
      en = 1'b1;
    end
    while (done_a !== 1'b1 && lat < 40) begin
      if (clr_last && lat == LANES - 1 + freeze) err_clr = 1'b1;
      tick();
      lat++;
      err_clr = 1'b0;
      start   = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(LANES + freeze));
    chk({tag, "_dout"},  dout_a,  exp_dout);
    chk({tag, "_valid"}, valid_a, (nfail == 0));
    chk({tag, "_mask"},  mask_a,  exp_mask);
    chk({tag, "_cnt_a"}, cnt_a,   64'(exp_cnt_a));
    chk({tag, "_done_b"}, done_b, 1'b1);
    chk({tag, "_dout_b"}, dout_b, exp_dout);
    chk({tag, "_cnt_b"}, cnt_b,   64'(exp_cnt_b));
    if (hold > 0) begin
      en = 1'b0;
      repeat (hold) tick();
      chk({tag, "_done_held"}, done_a, 1'b1);
      en = 1'b1;
    end
    tick();
    chk({tag, "_done_fall"}, done_a, 1'b0);
    chk({tag, "_busy_fall"}, busy_a, 1'b0);
    chk({tag, "_dout_hold"}, dout_a, exp_dout);
    tick();
    chk({tag, "_no_restart"}, busy_a, 1'b0);
  endtask

  initial begin
    logic [23:0] din;
    logic [11:0] cw;
    logic        rd;
    reset   = 1'b1;
    en      = 1'b1;
    start   = 1'b0;
    READ    = 1'b0;
    err_clr = 1'b0;
    DIN     = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_dout", dout_a, 24'h0);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_mask", mask_a, 2'b00);
    chk("rst_cnt", cnt_a, 16'h0);

    run_op("wr21", 1'b0, 24'h000021, 0, 1'b0, 1'b0, 0);
    chk("wr21_const", dout_a, 24'h2B9197);
    run_op("rd_ok", 1'b1, 24'h32E197, 0, 1'b0, 1'b0, 0);
    chk("rd_ok_const", dout_a, 24'h000031);
    run_op("rd_f1", 1'b1, 24'h32E196, 0, 1'b0, 1'b0, 0);
    chk("rd_f1_const", mask_a, 2'b01);
    run_op("rd_f2", 1'b1, 24'h32F196, 0, 1'b0, 1'b0, 0);
    chk("rd_f2_const", cnt_a, 16'd3);

    en      = 1'b0;
    err_clr = 1'b1;
    tick();
    chk("clr_frozen", cnt_a, 64'(exp_cnt_a));
    en = 1'b1;
    tick();
    err_clr   = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    chk("clr_a", cnt_a, 16'd0);
    chk("clr_b", cnt_b, 2'd0);

    repeat (3) run_op("sat", 1'b1, 24'h32F196, 0, 1'b0, 1'b0, 0);
    chk("sat_b_const", cnt_b, 2'd3);
    run_op("clr_coinc", 1'b1, 24'h32F196, 0, 1'b0, 1'b1, 0);
    run_op("dbl_start", 1'b0, 24'h0000A5, 0, 1'b1, 1'b0, 0);
    run_op("freeze", 1'b1, 24'h32E197, 3, 1'b0, 1'b0, 0);
    run_op("hold", 1'b0, 24'h00005C, 0, 1'b0, 1'b0, 2);
    run_op("pre_rst", 1'b1, 24'h32F196, 0, 1'b0, 1'b0, 0);

    start = 1'b1;
    READ  = 1'b1;
    DIN   = 24'h32F196;
    tick();
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    chk("abort_dout", dout_a, 24'h0);
    chk("abort_valid", valid_a, 1'b0);
    chk("abort_mask", mask_a, 2'b00);
    chk("abort_cnt", cnt_a, 16'h0);
    chk("abort_busy", busy_a, 1'b0);
    repeat (4) begin
      chk("abort_no_done", done_a, 1'b0);
      tick();
    end
    run_op("wr00", 1'b0, 24'h000000, 0, 1'b0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      rd  = 1'($urandom);
      din = 24'($urandom);
      if (rd) begin
        for (int i = 0; i < LANES; i++) begin
          cw = ref_cw(4'($urandom));
          if ($urandom_range(9, 0) < 3) cw = cw ^ (12'd1 << $urandom_range(11, 0));
          din[12*i +: 12] = cw;
        end
      end
      run_op("rand", rd, din, 0, 1'b0, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
